// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state type, byte constants and SPI mode decode
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } spi_state_e;

   // Eight bits, two SCLK edges per bit.
   localparam int EDGES_PER_BYTE = 16;
   localparam int EDGE_CNT_W     = 5;
   localparam logic [EDGE_CNT_W-1:0] LAST_EDGE = EDGE_CNT_W'(EDGES_PER_BYTE - 1);

   // Clock polarity: idle level of SCLK.
   function automatic logic spi_cpol(input int spi_mode);
      return spi_mode[1];
   endfunction

   // Clock phase: 0 samples on the leading edge, 1 samples on the trailing edge.
   function automatic logic spi_cpha(input int spi_mode);
      return spi_mode[0];
   endfunction

endpackage

// File: rtl/spi_edge_timer.sv
// rtl/spi_edge_timer.sv - half-bit timer and SCLK edge counter for the SPI byte master
module spi_edge_timer
   import spi_pkg::*;
#(
   parameter int CLKS_PER_HALF_BIT = 4
)
(
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic run,
   output logic edge_stb,
   output logic leading,
   output logic last_edge
);

   localparam logic [7:0] HALF_TC = 8'(CLKS_PER_HALF_BIT - 1);

   logic [7:0]            half_q, half_d;
   logic [EDGE_CNT_W-1:0] edge_q, edge_d;

   // edge_q counts edges already produced, so the upcoming edge is odd (leading) when it is even
   assign edge_stb  = run && (half_q == HALF_TC);
   assign leading   = ~edge_q[0];
   assign last_edge = (edge_q == LAST_EDGE);

   // next-state: restart on a new byte, otherwise advance while a byte is shifting
   always_comb begin
      half_d = half_q;
      edge_d = edge_q;
      if (start) begin
         half_d = '0;
         edge_d = '0;
      end else if (run) begin
         if (edge_stb) begin
            half_d = '0;
            edge_d = edge_q + 5'd1;
         end else begin
            half_d = half_q + 8'd1;
         end
      end
   end

   // timer and edge counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         half_q <= '0;
         edge_q <= '0;
      end else begin
         half_q <= half_d;
         edge_q <= edge_d;
      end
   end

endmodule

// File: rtl/spi_byte_master.sv
// rtl/spi_byte_master.sv - byte-level SPI initiator between the command processor and the SPI pins
// Build option: SPI_LOOPBACK_EN samples the block's own MOSI instead of the selected MISO line.
module spi_byte_master
   import spi_pkg::*;
#(
   parameter int CLKS_PER_HALF_BIT = 4,
   parameter int SPI_MODE          = 0
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] spitx,
   input  logic       spitxdv,
   output logic       spitxready,
   output logic [7:0] spirx,
   output logic       spirxdv,
   input  logic [2:0] spimisossel,
   input  logic [7:0] spimiso,
   output logic       spisclk,
   output logic       spimosi
);

   localparam logic CPOL = spi_cpol(SPI_MODE);
   localparam logic CPHA = spi_cpha(SPI_MODE);

   spi_state_e state_q, state_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] rx_q, rx_d;
   logic       mosi_q, mosi_d;
   logic       sclk_q, sclk_d;
   logic [7:0] spirx_q, spirx_d;
   logic       spirxdv_q, spirxdv_d;
   logic       ready_q, ready_d;
   logic       accept;
   logic       edge_stb, leading, last_edge;
   logic       sample_now, drive_now;
   logic       sample_bit;

   spi_edge_timer #(
      .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
   ) u_edge_timer (
      .clk      (clk),
      .rst      (rst),
      .start    (accept),
      .run      (state_q == SHIFT),
      .edge_stb (edge_stb),
      .leading  (leading),
      .last_edge(last_edge)
   );

   // CPHA=0 samples leading / drives trailing (bit 7 already out at acceptance);
   // CPHA=1 drives leading / samples trailing.
   assign sample_now = edge_stb && (leading ^ CPHA);
   assign drive_now  = edge_stb && (CPHA ? leading : (!leading && !last_edge));

`ifdef SPI_LOOPBACK_EN
   logic unused_miso;
   assign unused_miso = ^{spimiso, spimisossel};
   assign sample_bit  = mosi_q;
`else
   logic [2:0] misosel_q;

   // latch the MISO select at acceptance so mid-byte changes cannot redirect sampling
   always_ff @(posedge clk) begin
      if (rst) begin
         misosel_q <= '0;
      end else if (accept) begin
         misosel_q <= spimisossel;
      end
   end

   assign sample_bit = spimiso[misosel_q];
`endif

   // FSM next-state and datapath updates
   always_comb begin
      state_d   = state_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      mosi_d    = mosi_q;
      sclk_d    = sclk_q;
      spirx_d   = spirx_q;
      spirxdv_d = 1'b0;
      ready_d   = ready_q;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (spitxdv) begin
               accept  = 1'b1;
               ready_d = 1'b0;
               rx_d    = '0;
               sclk_d  = CPOL;
               if (!CPHA) begin
                  mosi_d = spitx[7];
                  tx_d   = {spitx[6:0], 1'b0};
               end else begin
                  tx_d = spitx;
               end
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (edge_stb) begin
               sclk_d = ~sclk_q;
               if (sample_now) begin
                  rx_d = {rx_q[6:0], sample_bit};
               end
               if (drive_now) begin
                  mosi_d = tx_q[7];
                  tx_d   = {tx_q[6:0], 1'b0};
               end
               if (last_edge) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            spirx_d   = rx_q;
            spirxdv_d = 1'b1;
            ready_d   = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   // state and output registers; reset abandons any byte in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         tx_q      <= '0;
         rx_q      <= '0;
         mosi_q    <= 1'b0;
         sclk_q    <= CPOL;
         spirx_q   <= '0;
         spirxdv_q <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         mosi_q    <= mosi_d;
         sclk_q    <= sclk_d;
         spirx_q   <= spirx_d;
         spirxdv_q <= spirxdv_d;
         ready_q   <= ready_d;
      end
   end

   assign spitxready = ready_q;
   assign spirx      = spirx_q;
   assign spirxdv    = spirxdv_q;
   assign spisclk    = sclk_q;
   assign spimosi    = mosi_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// tb/tb_spi_byte_master.sv - scoreboard bench for spi_byte_master in all four SPI modes
module tb_spi_byte_master;

   typedef struct {
      int         g;
      logic [7:0] rx;
      logic [7:0] tx;
      int         cyc;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   logic       rst_a      [4];
   logic [7:0] spitx_a    [4];
   logic       spitxdv_a  [4];
   logic [2:0] sel_a      [4];
   logic [7:0] spimiso_a  [4];
   logic       ready_a    [4];
   logic [7:0] spirx_a    [4];
   logic       rxdv_a     [4];
   logic       sclk_a     [4];
   logic       mosi_a     [4];

   logic [7:0] slave_byte [4];
   int         slave_line [4];
   int         n_a        [4] = '{default: 0};
   int         low_a      [4] = '{default: 0};
   logic [7:0] cap_a      [4] = '{default: 8'h00};
   bit         prev_ready [4] = '{default: 1'b1};
   logic       prev_sclk  [4] = '{default: 1'b0};

   function automatic int h_of(input int g);
`ifdef SPI_LOOPBACK_EN
      return 3;
`else
      return (g == 0) ? 4 : 2;
`endif
   endfunction

   function automatic logic cpol_of(input int g);
      return (g >= 2);
   endfunction

   // Slave presents MSB first; CPHA=0 shifts after each trailing edge, CPHA=1 after each leading edge
   // except the first. Unselected lines carry the inverted bit.
   function automatic logic [7:0] miso_vec(input int g, input logic [7:0] bv, input int line, input int n);
      int   b;
      logic bitv;
      b = (g % 2 == 1) ? (n - 1) / 2 : n / 2;
      if (b < 0) b = 0;
      if (b > 7) b = 7;
      bitv = bv[3'(7 - b)];
      miso_vec = {8{~bitv}};
      miso_vec[line[2:0]] = bitv;
   endfunction

   for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      assign spimiso_a[gi] = miso_vec(gi, slave_byte[gi], slave_line[gi], n_a[gi]);

      spi_byte_master #(
         .CLKS_PER_HALF_BIT(h_of(gi)),
         .SPI_MODE         (gi)
      ) u_dut (
         .clk        (clk),
         .rst        (rst_a[gi]),
         .spitx      (spitx_a[gi]),
         .spitxdv    (spitxdv_a[gi]),
         .spitxready (ready_a[gi]),
         .spirx      (spirx_a[gi]),
         .spirxdv    (rxdv_a[gi]),
         .spimisossel(sel_a[gi]),
         .spimiso    (spimiso_a[gi]),
         .spisclk    (sclk_a[gi]),
         .spimosi    (mosi_a[gi])
      );
   end

   task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s inst%0d: got 0x%0h required 0x%0h", name, g, act, exp);
   endtask

   // Monitor and slave: pop the scoreboard on each spirxdv, and track SCLK edges / MOSI bits per byte.
   always @(negedge clk) begin
      for (int g = 0; g < 4; g++) begin
         if (rxdv_a[g] === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_rxdv inst%0d: got strobe with spirx 0x%0h at cycle %0d, required none", g, spirx_a[g], cyc);
            end else begin
               mon_e = sb_q.pop_front();
               check("rx_inst",   g, 32'(g),           32'(mon_e.g));
               check("spirx",     g, 32'(spirx_a[g]),  32'(mon_e.rx));
               check("mosi_byte", g, 32'(cap_a[g]),    32'(mon_e.tx));
               check("rxdv_cyc",  g, 32'(cyc),         32'(mon_e.cyc));
               check("sclk_edges",g, 32'(n_a[g]),      32'(16));
               check("busy_cyc",  g, 32'(low_a[g]),    32'(16 * h_of(g) + 1));
               check("sclk_end",  g, 32'(sclk_a[g]),   32'(cpol_of(g)));
            end
         end
         if (ready_a[g] === 1'b0) begin
            if (prev_ready[g]) begin
               n_a[g]   = 0;
               low_a[g] = 0;
               cap_a[g] = 8'h00;
            end
            low_a[g]++;
            if (sclk_a[g] !== prev_sclk[g]) begin
               n_a[g]++;
               if ((n_a[g] % 2 == 1) == (g % 2 == 0)) cap_a[g] = {cap_a[g][6:0], mosi_a[g]};
            end
         end
         prev_ready[g] = (ready_a[g] === 1'b1);
         prev_sclk[g]  = sclk_a[g];
      end
   end

   task automatic send(input int g, input logic [7:0] tx, input logic [7:0] sb, input int line,
                       input int gap, input bit expect_done, output int t_acc);
      int   k;
      exp_t e;
      k = 0;
      while (ready_a[g] !== 1'b1 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 5000) begin
         n_checks++;
         $display("FAIL ready_wait inst%0d: spitxready %b after %0d cycles, required 1", g, ready_a[g], k);
      end
      repeat (gap) @(negedge clk);
      check("sclk_idle", g, 32'(sclk_a[g]), 32'(cpol_of(g)));
      slave_byte[g] = sb;
      slave_line[g] = line;
      spitx_a[g]    = tx;
      sel_a[g]      = 3'(line);
      spitxdv_a[g]  = 1'b1;
      t_acc = cyc + 1;
      if (expect_done) begin
         e.g   = g;
         e.tx  = tx;
`ifdef SPI_LOOPBACK_EN
         e.rx  = tx;
`else
         e.rx  = sb;
`endif
         e.cyc = t_acc + 16 * h_of(g) + 1;
         sb_q.push_back(e);
      end
      @(negedge clk);
      spitxdv_a[g] = 1'b0;
   endtask

   task automatic run_instance(input int g);
      int t;
      int k;
      if (g == 0) send(g, 8'hA5, 8'h3C, 2, 0, 1'b1, t);
      else        send(g, 8'h81, 8'h7E, 2, 0, 1'b1, t);
`ifdef SPI_LOOPBACK_EN
      send(g, 8'h5A, 8'hC3, 2, 0, 1'b1, t);
`endif
      for (int i = 0; i < 6; i++) begin
         send(g, 8'($urandom), 8'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'b1, t);
      end
      // request while busy must be dropped
      send(g, 8'($urandom), 8'($urandom), 1, 1, 1'b1, t);
      while (cyc < t + 9) @(negedge clk);
      spitx_a[g]   = 8'($urandom);
      spitxdv_a[g] = 1'b1;
      @(negedge clk);
      spitxdv_a[g] = 1'b0;
      // select change after acceptance must not redirect sampling
      send(g, 8'h96, 8'($urandom), 2, 0, 1'b1, t);
      while (cyc < t + 2) @(negedge clk);
      sel_a[g] = 3'd5;
      // reset mid-byte abandons the transfer
      send(g, 8'hFF, 8'($urandom), 3, 0, 1'b0, t);
      while (cyc < t + 19) @(negedge clk);
      rst_a[g] = 1'b1;
      @(negedge clk);
      check("rst_sclk",  g, 32'(sclk_a[g]),  32'(cpol_of(g)));
      check("rst_mosi",  g, 32'(mosi_a[g]),  32'(0));
      check("rst_ready", g, 32'(ready_a[g]), 32'(1));
      check("rst_rxdv",  g, 32'(rxdv_a[g]),  32'(0));
      rst_a[g] = 1'b0;
      send(g, 8'($urandom), 8'($urandom), int'($urandom_range(0, 7)), 0, 1'b1, t);
      k = 0;
      while (sb_q.size() != 0 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      check("drain", g, 32'(sb_q.size()), 32'(0));
   endtask

   initial begin
      for (int g = 0; g < 4; g++) begin
         rst_a[g]      = 1'b1;
         spitx_a[g]    = 8'h00;
         spitxdv_a[g]  = 1'b0;
         sel_a[g]      = 3'd0;
         slave_byte[g] = 8'h00;
         slave_line[g] = 0;
      end
      repeat (3) @(negedge clk);
      for (int g = 0; g < 4; g++) begin
         check("reset_sclk",  g, 32'(sclk_a[g]),  32'(cpol_of(g)));
         check("reset_mosi",  g, 32'(mosi_a[g]),  32'(0));
         check("reset_spirx", g, 32'(spirx_a[g]), 32'(0));
         check("reset_rxdv",  g, 32'(rxdv_a[g]),  32'(0));
         check("reset_ready", g, 32'(ready_a[g]), 32'(1));
         rst_a[g] = 1'b0;
      end
      @(negedge clk);
      for (int g = 0; g < 4; g++) run_instance(g);
      repeat (40) @(negedge clk);
      check("final_drain", 0, 32'(sb_q.size()), 32'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/spi_byte_master.md
# spi_byte_master

Byte-level SPI initiator that serves the command processor's SPI handshake (`spitx`/`spitxdv`/`spitxready` → `spirx`/`spirxdv`). It accepts one byte per request, shifts it MSB-first on `spimosi` while generating `spisclk`, and captures the byte returned on the selected MISO line. It sits between `command_processor` and the board's SPI pins. Chip select stays with the command processor (`spics`); this block never touches CS.

## Interface
- `CLKS_PER_HALF_BIT`, default 4: `clk` cycles per SCLK half-period; legal values 2..255.
- `SPI_MODE`, default 0: CPOL = `SPI_MODE[1]`, CPHA = `SPI_MODE[0]`.
- `clk` in, 1: system clock, same domain as `command_processor`.
- `rst` in, 1: one clock; reset is synchronous and active-high.
- `spitx` in, 8: byte to transmit.
- `spitxdv` in, 1: transmit request; sampled only while `spitxready`=1.
- `spitxready` out, 1: idle, can accept a byte.
- `spirx` out, 8: last received byte; held until the next byte completes.
- `spirxdv` out, 1: one-cycle pulse when `spirx` updates.
- `spimisossel` in, 3: selects the MISO line; latched at byte acceptance.
- `spimiso` in, 8: MISO lines from up to 8 chips.
- `spisclk` out, 1: SPI clock.
- `spimosi` out, 1: SPI data out.

## Operation
- Reset values: `spisclk`=CPOL, `spimosi`=0, `spirx`=0, `spirxdv`=0, `spitxready`=1, state IDLE, counters 0. Reset mid-byte abandons the transfer immediately; no `spirxdv` is issued.
- IDLE: `spitxready`=1. If `spitxdv`=1, latch `spitx` into the shift register, latch `spimisossel` into `misosel_q`, clear the edge counter and the half-bit timer, and go to SHIFT. `spitxready` drops on the next cycle.
- SHIFT: the half-bit timer counts 0..`CLKS_PER_HALF_BIT`-1. On terminal count it toggles `spisclk` and increments the edge counter (1..16). Odd edges are leading; even edges are trailing.
  - CPHA=0: `spimosi` = bit7 from the cycle after acceptance. Sample `spimiso[misosel_q]` on leading edges. Shift out the next bit on trailing edges, except edge 16.
  - CPHA=1: drive the next bit on leading edges (bit7 on edge 1). Sample on trailing edges.
  - Received bits shift in LSB-side, so the first sampled bit ends up in `spirx[7]`.
- After edge 16: `spisclk` is back at CPOL. Go to DONE.
- DONE (one cycle): `spirx` ← shift-in register, `spirxdv`=1, `spitxready`=1, go to IDLE. `spimosi` holds its last value until the next acceptance.
- `spitxdv` while busy is ignored, with no queueing. `spitxdv` in the DONE cycle is also ignored; it is accepted from IDLE only.
- `spimisossel` changes mid-byte have no effect.

## Timing
- Acceptance at cycle T (IDLE with `spitxdv`=1). Edge k registers at cycle T+k·H, where H=`CLKS_PER_HALF_BIT`.
- `spirxdv` and `spitxready` are high at T+16H+1.
- Next acceptance is possible at T+16H+2 at the earliest.
- Byte period: 16H+2 cycles.
- All outputs are registered. The MISO sample is taken directly from the pin on the sample-edge cycle, with no synchronizer; SCLK is slow relative to `clk`.

## Configuration
- `SPI_LOOPBACK_EN` defined: the sample source is the block's own registered `spimosi` instead of `spimiso[misosel_q]`. `spirx` then equals the transmitted byte (all modes), and `spimiso`/`spimisossel` are unused.
- Not defined: normal MISO sampling as above.

## Structure
- Package `spi_pkg`:
  - state enum IDLE/SHIFT/DONE;
  - `EDGES_PER_BYTE`=16;
  - CPOL/CPHA decode functions from `SPI_MODE`.
- One natural sub-module, `spi_edge_timer`:
  - half-bit counter producing `edge_stb`, `leading`, `last_edge`;
  - reset by `rst` or a start pulse.
- Shift registers and the FSM live in `spi_byte_master`.

## Test plan
- Mode 0, H=4: send 0xA5 with `spimiso[2]` driven as slave byte 0x3C and `spimisossel`=2.
  - Required: MOSI bits 1,0,1,0,0,1,0,1 stable at each rising edge.
  - Required: `spirx`=0x3C.
  - Required: `spirxdv` at T+65; exactly 16 SCLK edges.
- Modes 1, 2, 3, H=2: send 0x81 with slave byte 0x7E. Required: `spirx`=0x7E, and SCLK idles at CPOL before and after the byte.
- `spitxdv` pulsed at T+10 during a byte: ignored. Required: only one `spirxdv`, and `spitxready` stays 0 until T+16H+1.
- `spimisossel` changed from 2 to 5 at T+3: samples still come from line 2.
- `rst` asserted at T+20: next cycle `spisclk`=CPOL, `spimosi`=0, `spitxready`=1, and no `spirxdv`. A new byte afterwards completes correctly.
- `SPI_LOOPBACK_EN`, H=3: send 0x5A. Required: `spirx`=0x5A regardless of `spimiso`.
